// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: fetch FSM state encoding, opcode and branch
// constants used by both the sequencer and the decoder.
package cpu_ctrl_pkg;
  localparam logic [1:0] RESET     = 2'd0;
  localparam logic [1:0] FETCH     = 2'd1;
  localparam logic [1:0] FETCH_IMM = 2'd2;
  localparam logic [1:0] S_INTR    = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET     = RESET,
    ST_FETCH     = FETCH,
    ST_FETCH_IMM = FETCH_IMM,
    ST_INTR      = S_INTR
  } state_t;

  localparam int IMM_OPCODE_DEF = 12;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_IMM = 4'hC;
  localparam logic [3:0] OP_RTI = 4'hF;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JUMP = 2'd2;
  localparam logic [1:0] BR_RTI  = 2'd3;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irq_prio_latch.sv
// Edge-latched interrupt pending bits with mask gating and a fixed-priority
// encoder; line 0 wins.
module irq_prio_latch #(
  parameter int NUM_IRQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_mask,
  input  logic               i_ack,
  input  logic [ID_W-1:0]    i_ack_id,
  output logic               o_eligible_any,
  output logic [ID_W-1:0]    o_winner
);
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_elig;

  assign w_rise = i_irq & ~r_prev;
  assign w_elig = r_pend & i_mask;
  assign o_eligible_any = |w_elig;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      w_clr[i] = i_ack && (i_ack_id == ID_W'(i));
  end

  // Scan high to low so the lowest eligible index is the last one written.
  always_comb begin
    o_winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (w_elig[i]) o_winner = ID_W'(i);
  end

  // Clear beats a coincident edge: a re-edge on a line being acked is absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= i_irq;
      r_pend <= (r_pend | w_rise) & ~w_clr;
    end
  end
endmodule

// File: rtl/fetch_issue_sequencer.sv
// Fetch/issue sequencing FSM: immediate-word fetch, prioritised interrupt
// acceptance with multi-cycle entry, and stall/flush handling.
module fetch_issue_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 4,
  parameter int IMM_OPCODE    = IMM_OPCODE_DEF,
  parameter int IMM_WORDS     = 1,
  parameter int NUM_IRQ       = 2,
  parameter int IRQ_ENTRY_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                flush,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                rti_done,
  output logic                PC_Write_En,
  output logic                IF_ID_Write_En,
  output logic                Inject_Bubble,
  output logic                Inject_Int,
  output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] irq_id,
  output logic                irq_ack,
  output logic                in_service
);
  localparam int ID_W  = id_width(NUM_IRQ);
  localparam int CNT_W = 3;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_imm_cnt, w_imm_nx;
  logic [CNT_W-1:0]   r_int_cnt, w_int_nx;
  logic               r_in_service;
  logic [ID_W-1:0]    r_irq_id;
  logic               w_accept;
  logic               w_elig_any;
  logic [ID_W-1:0]    w_winner;
  logic               w_is_imm;

  assign w_is_imm = (opcode == OPCODE_W'(IMM_OPCODE));

  irq_prio_latch #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_irq (
    .clk            (clk),
    .rst            (rst),
    .i_irq          (irq),
    .i_mask         (irq_mask),
    .i_ack          (w_accept),
    .i_ack_id       (w_winner),
    .o_eligible_any (w_elig_any),
    .o_winner       (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_imm_cnt    <= '0;
      r_int_cnt    <= '0;
      r_in_service <= 1'b0;
      r_irq_id     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_imm_cnt <= w_imm_nx;
      r_int_cnt <= w_int_nx;
      if (w_accept) begin
        r_in_service <= 1'b1;
        r_irq_id     <= w_winner;
      end else if (rti_done) begin
        r_in_service <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_imm_nx       = r_imm_cnt;
    w_int_nx       = r_int_cnt;
    w_accept       = 1'b0;
    PC_Write_En    = 1'b1;
    IF_ID_Write_En = 1'b1;
    Inject_Bubble  = 1'b0;
    Inject_Int     = 1'b0;
    case (r_state)
      ST_RESET: begin
        Inject_Bubble = 1'b1;
        w_state_nx    = ST_FETCH;
      end
      ST_FETCH: begin
        if (stall) begin
          PC_Write_En    = 1'b0;
          IF_ID_Write_En = 1'b0;
        end else if (flush) begin
          Inject_Bubble = 1'b1;
        end else if (w_elig_any && !r_in_service) begin
          Inject_Int = 1'b1;
          w_accept   = 1'b1;
          w_int_nx   = CNT_W'(1);
          w_state_nx = ST_INTR;
        end else if (w_is_imm) begin
          IF_ID_Write_En = 1'b0;
          Inject_Bubble  = 1'b1;
          w_imm_nx       = CNT_W'(1);
          w_state_nx     = ST_FETCH_IMM;
        end
      end
      ST_FETCH_IMM: begin
        if (stall) begin
          PC_Write_En    = 1'b0;
          IF_ID_Write_En = 1'b0;
        end else if (flush) begin
          Inject_Bubble = 1'b1;
          w_state_nx    = ST_FETCH;
        end else if (r_imm_cnt < CNT_W'(IMM_WORDS)) begin
          IF_ID_Write_En = 1'b0;
          Inject_Bubble  = 1'b1;
          w_imm_nx       = r_imm_cnt + CNT_W'(1);
        end else begin
          w_state_nx = ST_FETCH;
        end
      end
      ST_INTR: begin
        // PC loads the vector only on the last entry cycle.
        Inject_Bubble = 1'b1;
        Inject_Int    = 1'b1;
        if (stall) begin
          PC_Write_En    = 1'b0;
          IF_ID_Write_En = 1'b0;
        end else if (r_int_cnt == CNT_W'(IRQ_ENTRY_CYC)) begin
          w_state_nx = ST_FETCH;
        end else begin
          PC_Write_En = 1'b0;
          w_int_nx    = r_int_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = ST_FETCH;
    endcase
    if (rst) begin
      PC_Write_En    = 1'b0;
      IF_ID_Write_En = 1'b0;
      Inject_Bubble  = 1'b1;
      Inject_Int     = 1'b0;
      w_accept       = 1'b0;
    end
  end

  assign irq_ack    = w_accept;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;
endmodule

// File: tb/tb_fetch_issue_sequencer.sv
// Directed bench for fetch_issue_sequencer with a behavioural model checked
// every cycle plus hand-computed spot checks.
module tb_fetch_issue_sequencer;
  localparam int OPCODE_W      = 4;
  localparam int IMM_OPCODE    = 12;
  localparam int IMM_WORDS     = 2;
  localparam int NUM_IRQ       = 4;
  localparam int IRQ_ENTRY_CYC = 3;

  localparam int M_BOOT = 0, M_RUN = 1, M_IMM = 2, M_ENTRY = 3;

  logic clk = 1'b0;
  logic rst, stall, flush, rti_done;
  logic [OPCODE_W-1:0] opcode;
  logic [NUM_IRQ-1:0]  irq, irq_mask;
  logic PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, irq_ack, in_service;
  logic [1:0] irq_id;

  int n_cmp = 0;
  int n_err = 0;

  fetch_issue_sequencer #(
    .OPCODE_W(OPCODE_W), .IMM_OPCODE(IMM_OPCODE), .IMM_WORDS(IMM_WORDS),
    .NUM_IRQ(NUM_IRQ), .IRQ_ENTRY_CYC(IRQ_ENTRY_CYC)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .stall(stall), .flush(flush),
    .irq(irq), .irq_mask(irq_mask), .rti_done(rti_done),
    .PC_Write_En(PC_Write_En), .IF_ID_Write_En(IF_ID_Write_En),
    .Inject_Bubble(Inject_Bubble), .Inject_Int(Inject_Int),
    .irq_id(irq_id), .irq_ack(irq_ack), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: mode, bubbles still owed, entry cycles left, pending lines.
  int m_mode = M_BOOT, n_mode = M_BOOT;
  int m_imm_left = 0, n_imm_left = 0;
  int m_ent_left = 0, n_ent_left = 0;
  logic [NUM_IRQ-1:0] m_pend = '0, n_pend = '0, m_prev = '0;
  logic [1:0] m_id = '0, n_id = '0;
  logic m_insvc = 1'b0, n_insvc = 1'b0;
  logic e_pc, e_ifw, e_bub, e_int, e_ack;
  int win;

  always @(negedge clk) begin
    win = -1;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (m_pend[i] && irq_mask[i]) win = i;
    e_pc = 1; e_ifw = 1; e_bub = 0; e_int = 0; e_ack = 0;
    n_mode = m_mode; n_imm_left = m_imm_left; n_ent_left = m_ent_left;
    n_id = m_id; n_insvc = m_insvc;
    n_pend = m_pend | (irq & ~m_prev);
    if (rst) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end else begin
      case (m_mode)
        M_BOOT: begin e_bub = 1; n_mode = M_RUN; end
        M_RUN:
          if (stall) begin e_pc = 0; e_ifw = 0; end
          else if (flush) e_bub = 1;
          else if (win >= 0 && !m_insvc) begin
            e_int = 1; e_ack = 1; n_id = 2'(win);
            n_ent_left = IRQ_ENTRY_CYC; n_mode = M_ENTRY;
          end else if (opcode == IMM_OPCODE) begin
            e_ifw = 0; e_bub = 1; n_imm_left = IMM_WORDS - 1; n_mode = M_IMM;
          end
        M_IMM:
          if (stall) begin e_pc = 0; e_ifw = 0; end
          else if (flush) begin e_bub = 1; n_mode = M_RUN; end
          else if (m_imm_left > 0) begin e_ifw = 0; e_bub = 1; n_imm_left = m_imm_left - 1; end
          else n_mode = M_RUN;
        default: begin
          e_bub = 1; e_int = 1;
          if (stall) begin e_pc = 0; e_ifw = 0; end
          else if (m_ent_left == 1) n_mode = M_RUN;
          else begin e_pc = 0; n_ent_left = m_ent_left - 1; end
        end
      endcase
    end
    if (e_ack) begin n_pend[win] = 1'b0; n_insvc = 1'b1; end
    else if (rti_done) n_insvc = 1'b0;
    chk("PC_Write_En", PC_Write_En, e_pc);
    chk("IF_ID_Write_En", IF_ID_Write_En, e_ifw);
    chk("Inject_Bubble", Inject_Bubble, e_bub);
    chk("Inject_Int", Inject_Int, e_int);
    chk("irq_ack", irq_ack, e_ack);
    chk("irq_id", irq_id, rst ? 2'd0 : m_id);
    chk("in_service", in_service, rst ? 1'b0 : m_insvc);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= M_BOOT; m_imm_left <= 0; m_ent_left <= 0;
      m_pend <= '0; m_prev <= '0; m_id <= '0; m_insvc <= 1'b0;
    end else begin
      m_mode <= n_mode; m_imm_left <= n_imm_left; m_ent_left <= n_ent_left;
      m_pend <= n_pend; m_prev <= irq; m_id <= n_id; m_insvc <= n_insvc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rti_pulse();
    rti_done = 1'b1; tick(); rti_done = 1'b0; tick();
  endtask

  int n_int, n_pc;

  initial begin
    rst = 1; opcode = '0; stall = 0; flush = 0; irq = '0; irq_mask = 4'hF; rti_done = 0;
    tick(); tick();
    #1 chk("rst_pcwe", PC_Write_En, 0); chk("rst_bubble", Inject_Bubble, 1);

    // reset release: one bubble, then steady fetch
    rst = 0; #1 chk("boot_bubble", Inject_Bubble, 1);
    tick(); chk("run_bubble", Inject_Bubble, 0); chk("run_ifwe", IF_ID_Write_En, 1);
    tick();

    // immediate instruction: two held cycles then defaults
    opcode = 4'd12; #1 chk("imm0_ifwe", IF_ID_Write_En, 0); chk("imm0_bub", Inject_Bubble, 1);
    tick(); opcode = 0; #1 chk("imm1_ifwe", IF_ID_Write_En, 0); chk("imm1_bub", Inject_Bubble, 1);
    tick(); chk("imm2_ifwe", IF_ID_Write_En, 1); chk("imm2_bub", Inject_Bubble, 0);
    tick();

    // wrong-path immediate opcode under flush
    opcode = 4'd12; flush = 1; #1 chk("flush_bub", Inject_Bubble, 1); chk("flush_ifwe", IF_ID_Write_En, 1);
    tick(); opcode = 0; flush = 0; #1 chk("flush_noimm", IF_ID_Write_En, 1);
    tick();

    // irq[3] and irq[1] together: 1 first, 3 after rti
    irq = 4'b1010; #1 chk("pair_noack", irq_ack, 0);
    tick(); irq = 0; #1 chk("pair_ack1", irq_ack, 1);
    tick(); chk("pair_id1", irq_id, 1); chk("pair_insvc", in_service, 1);
    repeat (6) tick();
    chk("pair_blocked", irq_ack, 0);
    rti_done = 1; #1 chk("pair_rti_cycle", irq_ack, 0);
    tick(); rti_done = 0; #1 chk("pair_ack2", irq_ack, 1);
    tick(); chk("pair_id3", irq_id, 3);
    repeat (4) tick(); rti_pulse();

    // irq during immediate fetch waits for return to FETCH
    opcode = 4'd12; tick(); opcode = 0; irq = 4'b0001; tick(); irq = 0;
    #1 chk("immirq_hold", irq_ack, 0);
    tick(); chk("immirq_ack", irq_ack, 1); chk("immirq_int", Inject_Int, 1);
    repeat (4) tick(); rti_pulse();

    // stall in 2nd entry cycle stretches entry to 4 cycles
    irq = 4'b0100; tick(); irq = 0; #1 chk("stall_ack", irq_ack, 1);
    tick();
    n_int = 0; n_pc = 0;
    for (int i = 0; i < 6; i++) begin
      stall = (i == 1); #1;
      if (Inject_Int) n_int++;
      if (Inject_Int && PC_Write_En) n_pc++;
      tick();
    end
    stall = 0;
    chk("entry_cycles", n_int, 4); chk("entry_pc_writes", n_pc, 1);
    rti_pulse();

    // masked line latches; stall beats acceptance; unmask then accept
    irq_mask = 4'b1110; irq = 4'b0001; tick(); irq = 0; repeat (3) tick();
    chk("masked_noack", irq_ack, 0);
    irq_mask = 4'hF; stall = 1; flush = 1; #1 chk("stallwins_ack", irq_ack, 0); chk("stallwins_pc", PC_Write_En, 0);
    tick(); stall = 0; flush = 0; #1 chk("unmask_ack", irq_ack, 1);
    tick(); irq = 4'b0010; tick(); irq = 0; repeat (4) tick();
    chk("nest_block", irq_ack, 0); chk("nest_insvc", in_service, 1);
    rti_done = 1; tick(); rti_done = 0; #1 chk("nest_ack", irq_ack, 1);
    tick(); chk("nest_id", irq_id, 1);
    repeat (3) tick(); rti_pulse();

    // reset mid immediate fetch drops pending
    opcode = 4'd12; tick(); opcode = 0; irq = 4'b1000; tick(); irq = 0;
    rst = 1; #1 chk("midrst_bub", Inject_Bubble, 1); chk("midrst_pc", PC_Write_En, 0);
    tick(); rst = 0; tick(); tick();
    chk("midrst_noack", irq_ack, 0); chk("midrst_insvc", in_service, 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
